adc_sample_avg: RTL

ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

---
 rtl/voltmeter_pkg.sv | 23 ++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/adc_sample_avg.sv | 87 ++++++++
 3 files changed

// File: rtl/voltmeter_pkg.sv
// Shared voltmeter definitions: widths, BCD converter state encoding,
// and the double-dabble digit adjust helper.
package voltmeter_pkg;
  localparam int ADC_CODE_W = 12;
  localparam int MV_W       = 14;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_SHIFT,
    BCD_DONE
  } bcd_state_e;

  // Add 3 to every BCD digit that is 5 or more, ahead of the next shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per cycle.
// A start pulse is only honoured in IDLE; starts while busy are dropped.
module bin2bcd_seq
  import voltmeter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MV_W-1:0]  mv,
  output logic             busy,
  output logic             valid,
  output logic [BCD_W-1:0] bcd
);
  bcd_state_e       state;
  logic [MV_W-1:0]  bin_q;
  logic [BCD_W-1:0] dig_q;
  logic [BCD_W-1:0] adj;
  logic [3:0]       iter;

  assign adj = bcd_add3(dig_q);

  // Converter FSM with registered busy/valid/bcd outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BCD_IDLE;
      bin_q <= '0;
      dig_q <= '0;
      iter  <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
      bcd   <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        BCD_IDLE: if (start) begin
          bin_q <= mv;
          dig_q <= '0;
          iter  <= '0;
          busy  <= 1'b1;
          state <= BCD_SHIFT;
        end
        BCD_SHIFT: begin
          dig_q <= {adj[BCD_W-2:0], bin_q[MV_W-1]};
          bin_q <= {bin_q[MV_W-2:0], 1'b0};
          iter  <= iter + 4'd1;
          if (iter == 4'(MV_W - 1)) state <= BCD_DONE;
        end
        BCD_DONE: begin
          bcd   <= dig_q;
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= BCD_IDLE;
        end
        default: state <= BCD_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/adc_sample_avg.sv
// XADC sample averager: sums 2^AVG_LOG2 codes, scales the mean to millivolts
// in a two-stage pipeline, optionally converts the result to BCD.
// Optional BCD path: define ADC_SAMPLE_AVG_BCD_EN.
module adc_sample_avg
  import voltmeter_pkg::*;
#(
  parameter int AVG_LOG2      = 4,
  parameter int FULL_SCALE_MV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        mv_valid,
  output logic [13:0] mv,
  output logic        bcd_valid,
  output logic [15:0] bcd,
  output logic        bcd_busy
);
  localparam int ACC_W  = ADC_CODE_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PROD_W = ADC_CODE_W + MV_W;
  localparam int STAGES = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ADC_CODE_W-1:0] code;
  logic [ACC_W-1:0]      acc, sum;
  logic [CNT_W-1:0]      cnt;
  logic                  win_done;
  logic [ADC_CODE_W-1:0] avg_q;
  logic [STAGES:1]       vld_pipe;
  logic [PROD_W-1:0]     prod;
  logic                  unused_bits;

  assign code     = sample_data[15:4];
  assign sum      = acc + ACC_W'(code);
  assign win_done = sample_valid && (cnt == CNT_LAST);
  assign prod     = PROD_W'(avg_q) * PROD_W'(FULL_SCALE_MV);
  assign mv_valid = vld_pipe[STAGES];
  // DRP status nibble and the truncated fraction are intentionally dropped.
  assign unused_bits = ^{sample_data[3:0], prod[ADC_CODE_W-1:0]};

  // Window accumulator; the completing sample restarts the window in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_valid) begin
      if (win_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1 latches the mean, stage 2 latches the scaled millivolt value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      avg_q    <= '0;
      mv       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], win_done};
      if (win_done)    avg_q <= sum[ACC_W-1:AVG_LOG2];
      if (vld_pipe[1]) mv    <= prod[PROD_W-1:ADC_CODE_W];
    end
  end

`ifdef ADC_SAMPLE_AVG_BCD_EN
  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mv_valid),
    .mv    (mv),
    .busy  (bcd_busy),
    .valid (bcd_valid),
    .bcd   (bcd)
  );
`else
  assign bcd       = '0;
  assign bcd_valid = 1'b0;
  assign bcd_busy  = 1'b0;
`endif
endmodule
